// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_tx and uart_rx.
//   DATA_W       - payload width of one UART character
//   BAUD_DEFAULT - clk cycles per bit at 50 MHz / 115200
//   tx_state_e   - transmitter FSM encoding (ST_PARITY is only used when
//                  UART_TX_PARITY_EN is defined)
package uart_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned BAUD_DEFAULT = 434;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous show-ahead FIFO buffering bytes for uart_tx.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write request; accepted when not full, or when full and a
//                pop happens in the same cycle
//   pop        : remove the head entry (ignored when empty)
//   rdata      : current head entry (valid while !empty)
//   full/empty : occupancy flags decoded from the pointers
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; wrap-around is natural overflow of the PW-bit counters.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, 8N1 (8E1 with UART_TX_PARITY_EN).
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : byte to transmit
//   din_vld    : one-cycle write strobe for din
//   tx         : serial line, idle high, registered
//   busy       : FIFO non-empty or a frame in progress
//   drop       : one-cycle pulse after a byte was discarded on a full FIFO
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD       = BAUD_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              tx,
  output logic              busy,
  output logic              drop
);

  localparam int unsigned CNT_W = (BAUD > 1) ? $clog2(BAUD) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              drop_q, drop_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (din_vld),
    .pop   (fifo_pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end = (baud_cnt_q == BAUD_LAST);

  // Next-state, counters, shift register and the registered line value.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    baud_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (state_q != ST_IDLE && !bit_end) baud_cnt_d = baud_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_rdata);
`endif
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Popping on the last stop cycle gives back-to-back frames.
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_rdata);
`endif
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx follows the registered state, so the line lags the FSM by one cycle.
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase

    drop_d = din_vld && fifo_full && !fifo_pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      drop_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      drop_q     <= drop_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign drop = drop_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx with a frame-level
// reference model (FIFO occupancy + frame schedule) and a line decoder.
module tb_uart_tx;

  localparam int BAUD  = 434;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_vld;
  logic       tx;
  logic       busy;
  logic       drop;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;

  // Reference model: bytes waiting in the buffer, frame schedule, expectations.
  int         m_cnt    = 0;
  bit         m_active = 1'b0;
  int         m_next   = 0;
  bit         drop_exp = 1'b0;
  int         drop_seen = 0;
  logic [7:0] sb_q[$];
  int         start_q[$];

  // Line decoder state.
  bit          mon_on = 1'b0;
  int          mon_t  = 0;
  logic [10:0] mon_bits;

  uart_tx #(.BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .tx      (tx),
    .busy    (busy),
    .drop    (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // One clock with optional write; the model predicts pops, drops and busy.
  task automatic tick(input bit vld, input logic [7:0] d);
    int e;
    int pre;
    bit pop;
    e   = ecnt + 1;
    pre = m_cnt;
    pop = 1'b0;
    din     = d;
    din_vld = vld;
    if (m_active && e == m_next) begin
      if (m_cnt > 0) pop = 1'b1;
      else m_active = 1'b0;
    end else if (!m_active && m_cnt > 0) begin
      pop = 1'b1;
    end
    if (pop) begin
      m_active = 1'b1;
      m_next   = e + F;
      m_cnt--;
      start_q.push_back(e + 1);
    end
    drop_exp = 1'b0;
    if (vld) begin
      if (pre < DEPTH || pop) begin
        m_cnt++;
        sb_q.push_back(d);
      end else begin
        drop_exp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(m_active || m_cnt > 0));
    check("drop", 32'(drop), 32'(drop_exp));
    if (drop === 1'b1) drop_seen++;
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((m_active || m_cnt > 0 || sb_q.size() > 0 || mon_on) && n < 20 * F) begin
      tick(1'b0, 8'h00);
      n++;
    end
    if (n >= 20 * F) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got busy after %0d cycles, required idle", n);
    end
  endtask

  // Decoder: sample each bit in its middle, compare against the scoreboard.
  initial begin
    logic [7:0] data;
    int k;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_on = 1'b0;
      end else begin
        if (!mon_on) begin
          if (tx === 1'b0) begin
            mon_on = 1'b1;
            mon_t  = 0;
            if (start_q.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL unexpected_frame: start at edge %0d, required none", ecnt);
            end else begin
              check("start_edge", 32'(ecnt), 32'(start_q.pop_front()));
            end
          end
        end else begin
          mon_t++;
        end
        if (mon_on && (mon_t % BAUD) == BAUD / 2) begin
          k = mon_t / BAUD;
          mon_bits[k] = tx;
          if (k == NB - 1) begin
            data = mon_bits[8:1];
            check("start_bit", 32'(mon_bits[0]), 32'd0);
            check("stop_bit", 32'(mon_bits[NB-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", 32'(mon_bits[9]), 32'(^data));
`endif
            if (sb_q.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL unexpected_byte: got %0h, required none", data);
            end else begin
              check("byte", 32'(data), 32'(sb_q.pop_front()));
            end
            mon_on = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int e0;
    int n;
    rst_n   = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop", 32'(drop), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick(1'b0, 8'h00);

    // Single byte from idle.
    tick(1'b1, 8'h55);
    wait_done();

    // Back-to-back pair.
    tick(1'b1, 8'hA5);
    tick(1'b1, 8'h3C);
    wait_done();

    // Overflow: six writes, the sixth is dropped.
    drop_seen = 0;
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
    check("overflow_drops", 32'(drop_seen), 32'd1);

    // Full FIFO plus a write on the final stop cycle of the first frame.
    n = 0;
    while (ecnt + 1 != m_next && n < F + 10) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check("reach_stop_end", 32'(ecnt + 1), 32'(m_next));
    tick(1'b1, 8'h99);
    check("full_pop_drops", 32'(drop_seen), 32'd1);
    wait_done();

    // Reset during data bit 3 of 8'hF0 with two bytes queued.
    e0 = ecnt + 1;
    tick(1'b1, 8'hF0);
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    while (ecnt < e0 + 2 + 4 * BAUD + BAUD / 2) tick(1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_tx", 32'(tx), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_drop", 32'(drop), 32'd0);
    m_cnt    = 0;
    m_active = 1'b0;
    sb_q.delete();
    start_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) tick(1'b0, 8'h00);
    check("post_reset_tx", 32'(tx), 32'd1);

    // Parity-distinguishing pair.
    tick(1'b1, 8'h07);
    tick(1'b1, 8'h03);
    wait_done();

    // Random writes at random offsets, overlapping frames in flight.
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(0, F / 2));
      repeat (n) tick(1'b0, 8'h00);
      tick(1'b1, 8'($urandom));
    end
    wait_done();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("start_q_empty", 32'(start_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
